// File: rtl/hf_rx_pkg.sv
// hf_rx_pkg: shared state encoding, filter width helper and runtime-input defaults for the HF receiver
package hf_rx_pkg;
    typedef enum logic [1:0] {IDLE, SYNC, RUN, DRAIN} state_t;
    localparam int DEF_THRESHOLD = 40;
    localparam int DEF_DET_PHASE = 3;
    function automatic int filt_w(input int adc_w);
        return adc_w + 3;
    endfunction
endpackage

// File: rtl/hf_deriv_filter.sv
// hf_deriv_filter: 5-sample delay line and gaussian-derivative kernel f = (2*s4 + s3) - (2*s0 + s1)
module hf_deriv_filter
    import hf_rx_pkg::*;
#(
    parameter int ADC_W = 8
) (
    input  logic ck_1356meg,
    input  logic rst,
    input  logic [ADC_W-1:0] adc_d,
    output logic signed [filt_w(ADC_W)-1:0] f
);
    logic [4:0][ADC_W-1:0] s;
    // Sample pipeline, s[0] newest, runs every cycle regardless of receiver state
    always_ff @(posedge ck_1356meg or posedge rst)
        if (rst) s <= '0;
        else s <= {s[3:0], adc_d};
    assign f = $signed(({2'b0, s[4], 1'b0} + {3'b0, s[3]}) - ({2'b0, s[0], 1'b0} + {3'b0, s[1]}));
endmodule

// File: rtl/hf_subcarrier_rx.sv
// hf_subcarrier_rx: subcarrier edge detector, frame collector and SSP serialiser; HF_RX_STATS_EN adds mod_count
module hf_subcarrier_rx
    import hf_rx_pkg::*;
#(
    parameter int ADC_W = 8,
    parameter int SC_LOG2 = 4,
    parameter int FRAME_BITS = 8
) (
    input  logic ck_1356meg,
    input  logic rst,
    input  logic [ADC_W-1:0] adc_d,
    input  logic enable,
    input  logic [ADC_W+1:0] threshold,
    input  logic [SC_LOG2-1:0] det_phase,
    output logic curbit,
    output logic bit_valid,
    output logic busy,
    output logic ssp_clk,
    output logic ssp_frame,
`ifdef HF_RX_STATS_EN
    output logic ssp_din,
    output logic [15:0] mod_count
`else
    output logic ssp_din
`endif
);
    localparam int FW = filt_w(ADC_W);
    localparam int CW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);
    localparam logic signed [FW-1:0] ZERO = '0;
    state_t state, nxt;
    logic [SC_LOG2-1:0] phase;
    logic signed [FW-1:0] f, fall_max, rise_max, th;
    logic [FRAME_BITS-2:0] cbuf;
    logic [FRAME_BITS-1:0] word, tx_buf, tx_sh;
    logic [CW-1:0] ccnt, tx_cnt;
    logic wrap, collect, done, tx_last, tx_full, tx_on;
    hf_deriv_filter #(.ADC_W(ADC_W)) u_filt (
        .ck_1356meg(ck_1356meg),
        .rst(rst),
        .adc_d(adc_d),
        .f(f)
    );
    assign th = $signed({1'b0, threshold});
    assign wrap = &phase;
    assign collect = bit_valid && (state == SYNC || state == RUN);
    assign word = {cbuf, curbit};
    assign done = collect && ccnt == LAST;
    assign tx_last = !tx_on || tx_cnt == LAST;
    assign busy = state != IDLE;
    assign ssp_clk = busy && !phase[SC_LOG2-1];
    assign ssp_din = tx_on && tx_sh[FRAME_BITS-1];
    assign ssp_frame = tx_on && tx_cnt == '0;
    // State register
    always_ff @(posedge ck_1356meg or posedge rst)
        if (rst) state <= IDLE;
        else state <= nxt;
    // Next state: DRAIN leaves only on a period boundary once no frame remains to send
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = enable ? SYNC : IDLE;
            SYNC:    nxt = !enable ? IDLE : (bit_valid ? RUN : SYNC);
            RUN:     nxt = enable ? RUN : DRAIN;
            DRAIN:   nxt = (wrap && tx_last && !tx_full) ? IDLE : DRAIN;
            default: nxt = IDLE;
        endcase
    end
    // Phase counter, pinned to 0 in IDLE so each run starts at phase 0
    always_ff @(posedge ck_1356meg or posedge rst)
        if (rst) phase <= '0;
        else phase <= (state == IDLE || nxt == IDLE) ? '0 : phase + 1'b1;
    // Edge maxima tracking and per-period bit decision
    always_ff @(posedge ck_1356meg or posedge rst)
        if (rst) begin
            curbit <= 1'b0;
            bit_valid <= 1'b0;
            fall_max <= '0;
            rise_max <= '0;
        end else if (state == IDLE) begin
            bit_valid <= 1'b0;
            fall_max <= '0;
            rise_max <= '0;
        end else if (phase == det_phase) begin
            curbit <= (fall_max > th) && (rise_max < -th);
            bit_valid <= 1'b1;
            fall_max <= '0;
            rise_max <= '0;
        end else begin
            bit_valid <= 1'b0;
            if (f > ZERO && f > fall_max) fall_max <= f;
            if (f <= ZERO && f < rise_max) rise_max <= f;
        end
    // Collect buffer, MSB first; a full word moves to the tx buffer in the same cycle
    always_ff @(posedge ck_1356meg or posedge rst)
        if (rst) begin
            cbuf <= '0;
            ccnt <= '0;
            tx_buf <= '0;
            tx_full <= 1'b0;
        end else begin
            if (collect) begin
                cbuf <= word[FRAME_BITS-2:0];
                ccnt <= done ? '0 : ccnt + 1'b1;
            end else if (state == IDLE || state == DRAIN) ccnt <= '0;
            if (done) tx_buf <= word;
            tx_full <= done || (tx_full && !(wrap && tx_last));
        end
    // Serialiser: advances at each period boundary so ssp_din changes with the ssp_clk rising edge
    always_ff @(posedge ck_1356meg or posedge rst)
        if (rst) begin
            tx_sh <= '0;
            tx_cnt <= '0;
            tx_on <= 1'b0;
        end else if (wrap) begin
            if (tx_last) begin
                tx_on <= tx_full;
                tx_sh <= tx_buf;
                tx_cnt <= '0;
            end else begin
                tx_sh <= tx_sh << 1;
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
`ifdef HF_RX_STATS_EN
    // Saturating count of modulated decisions, restarted at the start of each run
    always_ff @(posedge ck_1356meg or posedge rst)
        if (rst) mod_count <= '0;
        else if (state == IDLE && enable) mod_count <= '0;
        else if (bit_valid && curbit && mod_count != 16'hFFFF) mod_count <= mod_count + 1'b1;
`endif
endmodule

// File: tb/tb_hf_subcarrier_rx.sv
// tb_hf_subcarrier_rx: directed checks of hf_subcarrier_rx at SC_LOG2=4 (u_a) and SC_LOG2=5 (u_b)
module tb_hf_subcarrier_rx;
    import hf_rx_pkg::*;
    logic ck = 1'b0;
    logic rst;
    logic [7:0] adc_a, adc_b;
    logic en_a, en_b;
    logic [9:0] thr_a, thr_b;
    logic [3:0] dp_a;
    logic [4:0] dp_b;
    logic cur_a, bv_a, busy_a, sclk_a, frm_a, din_a;
    logic cur_b, bv_b, busy_b, sclk_b, frm_b, din_b;
`ifdef HF_RX_STATS_EN
    logic [15:0] mc_a, mc_b;
`endif
    logic sel;
    logic o_cur, o_bv, o_busy, o_clk, o_frm, o_din;
    int k, per, mode, nbv, nones, pk_pos, pk_neg, errors, checks;
    logic [7:0] hi, lo;
    logic din_hist [64];
    logic frm_hist [64];

    always #5 ck = ~ck;

    hf_subcarrier_rx #(.ADC_W(8), .SC_LOG2(4), .FRAME_BITS(8)) u_a (
        .ck_1356meg(ck), .rst(rst), .adc_d(adc_a), .enable(en_a), .threshold(thr_a), .det_phase(dp_a),
        .curbit(cur_a), .bit_valid(bv_a), .busy(busy_a), .ssp_clk(sclk_a), .ssp_frame(frm_a),
`ifdef HF_RX_STATS_EN
        .ssp_din(din_a), .mod_count(mc_a)
`else
        .ssp_din(din_a)
`endif
    );

    hf_subcarrier_rx #(.ADC_W(8), .SC_LOG2(5), .FRAME_BITS(8)) u_b (
        .ck_1356meg(ck), .rst(rst), .adc_d(adc_b), .enable(en_b), .threshold(thr_b), .det_phase(dp_b),
        .curbit(cur_b), .bit_valid(bv_b), .busy(busy_b), .ssp_clk(sclk_b), .ssp_frame(frm_b),
`ifdef HF_RX_STATS_EN
        .ssp_din(din_b), .mod_count(mc_b)
`else
        .ssp_din(din_b)
`endif
    );

    assign o_cur = sel ? cur_b : cur_a;
    assign o_bv = sel ? bv_b : bv_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_clk = sel ? sclk_b : sclk_a;
    assign o_frm = sel ? frm_b : frm_a;
    assign o_din = sel ? din_b : din_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stimulus level for cycle k: low for half a period starting at phase 6 in modulated periods
    function automatic logic [7:0] lvl();
        int n, ph;
        logic m;
        if (k < 0) return hi;
        n = k / per;
        ph = k % per;
        m = (mode == 1) ? 1'b1 : (mode == 2) ? n[0] : 1'b0;
        return (m && ph >= 6 && ph < 6 + per / 2) ? lo : hi;
    endfunction

    task automatic record();
        int n, ph, fv;
        if (k >= 0) begin
            n = k / per;
            ph = k % per;
            if (o_bv) begin
                nbv++;
                if (o_cur) nones++;
            end
            if (n < 64 && ph == per / 2) begin
                din_hist[n] = o_din;
                frm_hist[n] = o_frm;
            end
            if (!sel) begin
                fv = int'($signed(u_a.f));
                if (fv > pk_pos) pk_pos = fv;
                if (fv < pk_neg) pk_neg = fv;
            end
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
        k++;
        record();
        if (sel) adc_b = lvl();
        else adc_a = lvl();
    endtask

    task automatic run_until(input int t);
        while (k < t) step();
    endtask

    task automatic start_run(input logic s, input int m, input logic [7:0] h, input logic [7:0] l);
        sel = s;
        per = s ? 32 : 16;
        mode = m;
        hi = h;
        lo = l;
        nbv = 0;
        nones = 0;
        pk_pos = 0;
        pk_neg = 0;
        for (int i = 0; i < 64; i++) begin
            din_hist[i] = 1'b0;
            frm_hist[i] = 1'b0;
        end
        k = -20;
        repeat (19) step();
        if (s) en_b = 1'b1;
        else en_a = 1'b1;
    endtask

    task automatic stop_and_wait(input string tag);
        int t;
        if (sel) en_b = 1'b0;
        else en_a = 1'b0;
        t = 0;
        while (o_busy && t < 2000) begin
            step();
            t++;
        end
        chk(tag, o_busy, 0);
    endtask

    function automatic logic [7:0] word_at(input int p);
        logic [7:0] w;
        for (int j = 0; j < 8; j++) w[7-j] = din_hist[p+j];
        return w;
    endfunction

    function automatic int frames(input int a, input int b);
        int c = 0;
        for (int p = a; p <= b; p++) if (frm_hist[p]) c++;
        return c;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        sel = 1'b0;
        rst = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        adc_a = 8'd128;
        adc_b = 8'd128;
        thr_a = 10'(DEF_THRESHOLD);
        thr_b = 10'(DEF_THRESHOLD);
        dp_a = 4'(DEF_DET_PHASE);
        dp_b = 5'(DEF_DET_PHASE);
        repeat (3) @(posedge ck);
        #1;
        chk("reset_a", {cur_a, bv_a, busy_a, sclk_a, frm_a, din_a}, 0);
        chk("reset_b", {cur_b, bv_b, busy_b, sclk_b, frm_b, din_b}, 0);
        rst = 1'b0;

        start_run(1'b0, 0, 8'd128, 8'd128);
        run_until(16);
        chk("flat_clk_ph0", o_clk, 1);
        run_until(23);
        chk("flat_clk_ph7", o_clk, 1);
        run_until(24);
        chk("flat_clk_ph8", o_clk, 0);
        run_until(511);
        chk("flat_busy", o_busy, 1);
        chk("flat_nvalid", nbv, 32);
        chk("flat_ones", nones, 0);
        chk("flat_word1", word_at(16), 8'h00);
        chk("flat_frames", frames(0, 31), 3);
        stop_and_wait("flat_drain");

        start_run(1'b0, 1, 8'd192, 8'd64);
        run_until(4);
        chk("sq_first_bv", o_bv, 1);
        chk("sq_first_bit", o_cur, 0);
        run_until(5);
        chk("sq_bv_pulse", o_bv, 0);
        run_until(84);
        chk("sq_bit5", {o_bv, o_cur}, 2'b11);
        run_until(312);
        en_a = 1'b0;
        run_until(383);
        chk("drain_busy_last", o_busy, 1);
        run_until(384);
        chk("drain_busy_fall", o_busy, 0);
        run_until(416);
        chk("sq_word0", word_at(8), 8'h7F);
        chk("sq_word1", word_at(16), 8'hFF);
        chk("sq_frames", frames(0, 24), 2);
        chk("sq_no_partial", {din_hist[24], frm_hist[24]}, 0);
        chk("sq_peak_pos", pk_pos, 384);
        chk("sq_peak_neg", pk_neg, -384);
        stop_and_wait("sq_idle");

        thr_a = 10'd48;
        start_run(1'b0, 1, 8'd136, 8'd120);
        run_until(80);
        chk("thr48_ones", nones, 0);
        chk("thr48_peak", pk_pos, 48);
        thr_a = 10'd47;
        run_until(160);
        chk("thr47_ones", nones, 5);
        chk("thr47_nvalid", nbv, 10);
        stop_and_wait("thr_drain");
        thr_a = 10'(DEF_THRESHOLD);

        start_run(1'b0, 1, 8'd192, 8'd64);
        run_until(168);
        chk("pre_rst_din", {o_busy, o_din}, 2'b11);
`ifdef HF_RX_STATS_EN
        chk("pre_rst_modcount", mc_a, 10);
`endif
        rst = 1'b1;
        en_a = 1'b0;
        #1;
        chk("async_rst_outs", {cur_a, bv_a, busy_a, sclk_a, frm_a, din_a}, 0);
`ifdef HF_RX_STATS_EN
        chk("async_rst_modcount", mc_a, 0);
`endif
        @(posedge ck);
        #1;
        rst = 1'b0;

        start_run(1'b1, 2, 8'd192, 8'd64);
        run_until(2 * 32 + 15);
        chk("b_clk_ph15", o_clk, 1);
        run_until(2 * 32 + 16);
        chk("b_clk_ph16", o_clk, 0);
        run_until(24 * 32 - 1);
        chk("b_word0", word_at(8), 8'h2A);
        chk("b_word1", word_at(16), 8'hAA);
        chk("b_frames", frames(0, 23), 2);
        stop_and_wait("b_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
